// File: rtl/song_sequencer.sv
// Timed playback controller for the music-sheet ROM: steps through notes, holds each
// for its duration, renders a square wave on speaker, and inserts a silent gap between notes.
`timescale 1ns/1ps
module song_sequencer #(
    parameter int unsigned TICK_CYCLES = 6250000,
    parameter int unsigned GAP_CYCLES  = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [19:0] note,
    input  logic [4:0]  duration,
    input  logic        done,
    output logic [9:0]  number,
    output logic        speaker,
    output logic        playing,
    output logic        finished
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_FINISH} state_t;

    state_t      r_state;
    logic [9:0]  r_number;
    logic        r_speaker;
    logic        r_playing;
    logic        r_finished;
    logic [19:0] r_note;
    logic [4:0]  r_dur;
    logic        r_last;
    logic [19:0] r_tone_cnt;
    logic [31:0] r_play_cnt;
    logic [31:0] r_gap_cnt;

    logic        w_eon_last;
    logic        w_eon_finish;
    logic [9:0]  w_eon_number;
    logic [31:0] w_play_last;
    logic        w_play_end;
    logic        w_tone_wrap;
    logic        w_tone_high;
    logic        w_gap_end;

    // A zero-duration note resolves end-of-note in LOAD, before last_r has been latched.
    assign w_eon_last   = (r_state == S_LOAD) ? done : r_last;
    assign w_eon_finish = w_eon_last && !loop;
    assign w_eon_number = w_eon_last ? 10'd0 : r_number + 10'd1;

    assign w_play_last = 32'(r_dur) * TICK_CYCLES - 32'd1;
    assign w_play_end  = (r_play_cnt == w_play_last);
    // Silent periods (0/1) keep the tone counter parked at zero.
    assign w_tone_wrap = (r_note < 20'd2) || (r_tone_cnt == r_note - 20'd1);
    assign w_tone_high = (r_note >= 20'd2) && (r_tone_cnt < (r_note >> 1));
    assign w_gap_end   = (r_gap_cnt == 32'(GAP_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_number   <= 10'd0;
            r_speaker  <= 1'b0;
            r_playing  <= 1'b0;
            r_finished <= 1'b0;
            r_note     <= 20'd0;
            r_dur      <= 5'd0;
            r_last     <= 1'b0;
            r_tone_cnt <= 20'd0;
            r_play_cnt <= 32'd0;
            r_gap_cnt  <= 32'd0;
        end else if (stop) begin
            r_state    <= S_IDLE;
            r_number   <= 10'd0;
            r_speaker  <= 1'b0;
            r_playing  <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_number  <= 10'd0;
                    r_speaker <= 1'b0;
                    if (start) begin
                        r_state   <= S_LOAD;
                        r_playing <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_note    <= note;
                    r_dur     <= duration;
                    r_last    <= done;
                    r_speaker <= 1'b0;
                    if (duration == 5'd0) begin
                        if (w_eon_finish) begin
                            r_state    <= S_FINISH;
                            r_playing  <= 1'b0;
                            r_finished <= 1'b1;
                        end else begin
                            r_number <= w_eon_number;
                        end
                    end else begin
                        r_state    <= S_PLAY;
                        r_tone_cnt <= 20'd0;
                        r_play_cnt <= 32'd0;
                    end
                end
                S_PLAY: begin
                    r_speaker  <= w_play_end ? 1'b0 : w_tone_high;
                    r_tone_cnt <= w_tone_wrap ? 20'd0 : r_tone_cnt + 20'd1;
                    r_play_cnt <= r_play_cnt + 32'd1;
                    if (w_play_end) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= 32'd0;
                    end
                end
                S_GAP: begin
                    r_speaker <= 1'b0;
                    if (w_gap_end) begin
                        if (w_eon_finish) begin
                            r_state    <= S_FINISH;
                            r_playing  <= 1'b0;
                            r_finished <= 1'b1;
                        end else begin
                            r_state  <= S_LOAD;
                            r_number <= w_eon_number;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 32'd1;
                    end
                end
                S_FINISH: begin
                    r_speaker <= 1'b0;
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_number   <= 10'd0;
                        r_playing  <= 1'b1;
                        r_finished <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign number   = r_number;
    assign speaker  = r_speaker;
    assign playing  = r_playing;
    assign finished = r_finished;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a behavioural ROM plus a per-cycle expected-output timeline
// built from note occupancy rules (LOAD, dur*TICK play cycles, GAP silence).
`timescale 1ns/1ps
module tb_song_sequencer;

    localparam int TICK = 10;
    localparam int GAP  = 4;

    typedef struct packed {
        logic [9:0] num;
        logic       spk;
        logic       ply;
        logic       fin;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, stop, loop;
    logic [19:0] note;
    logic [4:0]  duration;
    logic        done;
    logic [9:0]  number;
    logic        speaker, playing, finished;

    logic [19:0] rom_note [1024];
    logic [4:0]  rom_dur  [1024];
    logic        rom_done [1024];

    exp_t q[$];
    exp_t obs;
    int   total = 0;
    int   bad   = 0;

    song_sequencer #(.TICK_CYCLES(TICK), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .note(note), .duration(duration), .done(done),
        .number(number), .speaker(speaker), .playing(playing), .finished(finished)
    );

    assign note     = rom_note[number];
    assign duration = rom_dur[number];
    assign done     = rom_done[number];

    always #5 clk = ~clk;

    function automatic exp_t mk(int n, bit s, bit p, bit f);
        exp_t e;
        e.num = 10'(n);
        e.spk = s;
        e.ply = p;
        e.fin = f;
        return e;
    endfunction

    function automatic bit tone_hi(int n, int t);
        if (n < 2) return 1'b0;
        return (t % n) < (n / 2);
    endfunction

    // Expected outputs for each cycle after the start edge, as a flat timeline.
    task automatic gen(input bit lp, input int len);
        int idx = 0;
        int p;
        q.delete();
        while (q.size() < len) begin
            q.push_back(mk(idx, 1'b0, 1'b1, 1'b0));
            p = int'(rom_dur[idx]) * TICK;
            for (int j = 0; j < p; j++)
                q.push_back(mk(idx, (j > 0) && tone_hi(int'(rom_note[idx]), j - 1), 1'b1, 1'b0));
            if (rom_dur[idx] != 5'd0)
                for (int j = 0; j < GAP; j++) q.push_back(mk(idx, 1'b0, 1'b1, 1'b0));
            if (rom_done[idx] && !lp) begin
                while (q.size() < len) q.push_back(mk(idx, 1'b0, 1'b0, 1'b1));
            end else begin
                idx = rom_done[idx] ? 0 : (idx + 1) % 1024;
            end
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) begin
            rom_note[i] = 20'd0;
            rom_dur[i]  = 5'd0;
            rom_done[i] = 1'b0;
        end
    endtask

    task automatic spec_rom();
        clear_rom();
        rom_note[0] = 20'd8; rom_dur[0] = 5'd2; rom_done[0] = 1'b0;
        rom_note[1] = 20'd1; rom_dur[1] = 5'd1; rom_done[1] = 1'b0;
        rom_note[2] = 20'd6; rom_dur[2] = 5'd1; rom_done[2] = 1'b1;
    endtask

    task automatic go_idle();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        #3;
        obs = {number, speaker, playing, finished};
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0", obs);
        end
        @(negedge clk) reset = 1'b0;
        $display("test_reset: outputs=%h", obs);
    endtask

    task automatic test_playback(input string name, input bit lp, input bit noise, input int len);
        gen(lp, len);
        loop = lp;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            obs = {number, speaker, playing, finished};
            total++;
            if (obs !== q[i]) begin
                bad++;
                if (bad <= 30)
                    $display("FAIL %s cyc=%0d got num=%0d spk=%0b ply=%0b fin=%0b exp num=%0d spk=%0b ply=%0b fin=%0b",
                             name, i, obs.num, obs.spk, obs.ply, obs.fin, q[i].num, q[i].spk, q[i].ply, q[i].fin);
            end
            start = noise && q[i].ply && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        $display("%s: loop=%0b noise=%0b cycles=%0d", name, lp, noise, len);
    endtask

    task automatic test_stop();
        spec_rom();
        gen(1'b0, 11);
        loop = 1'b0;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = 1'b0;
            obs = {number, speaker, playing, finished};
            total++;
            if (obs !== q[i]) begin
                bad++;
                $display("FAIL stop_pre cyc=%0d got=%h exp=%h", i, obs, q[i]);
            end
        end
        stop = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stop = 1'b0; start = 1'b0;
            obs = {number, speaker, playing, finished};
            total++;
            if (obs !== 13'd0) begin
                bad++;
                $display("FAIL stop_idle cyc=%0d got=%h exp=0", i, obs);
            end
        end
        $display("test_stop: idle after stop");
    endtask

    task automatic test_async_reset();
        spec_rom();
        gen(1'b0, 22);
        loop = 1'b0;
        @(negedge clk) start = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            start = 1'b0;
            obs = {number, speaker, playing, finished};
            total++;
            if (obs !== q[i]) begin
                bad++;
                $display("FAIL areset_pre cyc=%0d got=%h exp=%h", i, obs, q[i]);
            end
        end
        #2 reset = 1'b1;
        #1;
        obs = {number, speaker, playing, finished};
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL areset_async got=%h exp=0", obs);
        end
        #1 reset = 1'b0;
        $display("test_async_reset: outputs=%h", obs);
        test_playback("after_reset", 1'b0, 1'b0, 60);
    endtask

    task automatic test_random_songs();
        int nlen;
        bit lp;
        for (int k = 0; k < 8; k++) begin
            clear_rom();
            nlen = $urandom_range(1, 6);
            for (int i = 0; i < nlen; i++) begin
                rom_note[i] = 20'($urandom_range(0, 12));
                rom_dur[i]  = 5'($urandom_range(0, 3));
                rom_done[i] = (i == nlen - 1);
            end
            lp = 1'($urandom_range(0, 1));
            go_idle();
            test_playback("random_song", lp, 1'b1, 150);
        end
    endtask

    task automatic test_wrap();
        clear_rom();
        rom_note[0] = 20'($urandom_range(2, 9));    rom_dur[0] = 5'd1;
        rom_note[1] = 20'($urandom_range(2, 9));    rom_dur[1] = 5'($urandom_range(0, 2));
        rom_note[1023] = 20'($urandom_range(2, 9)); rom_dur[1023] = 5'($urandom_range(0, 2));
        go_idle();
        test_playback("wrap", 1'($urandom_range(0, 1)), 1'b1, 1150);
    endtask

    initial begin
        test_reset();
        spec_rom();
        test_playback("single", 1'b0, 1'b0, 70);
        go_idle();
        test_playback("loop", 1'b1, 1'b0, 130);
        go_idle();
        spec_rom();
        rom_note[1] = 20'd8; rom_dur[1] = 5'd0;
        test_playback("zero_dur", 1'b0, 1'b0, 50);
        go_idle();
        test_stop();
        go_idle();
        test_async_reset();
        go_idle();
        spec_rom();
        test_playback("start_noise", 1'b0, 1'b1, 70);
        test_random_songs();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
